// File: rtl/glb_cfg_initiator_if.sv
// Bus interfaces for the global cfg initiator.
//   glb_host_if : host PIO request/response channel (valid/ready both ways).
//                 master = host, slave = cfg initiator.
//   glb_cfg_if  : tile configuration bus into the westmost tile.
//                 master = cfg initiator, slave = tile chain.

interface glb_host_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface glb_cfg_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              cfg_wr_clk_en;
    logic              cfg_wr_en;
    logic [ADDR_W-1:0] cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic              cfg_rd_clk_en;
    logic              cfg_rd_en;
    logic [ADDR_W-1:0] cfg_rd_addr;
    logic [DATA_W-1:0] cfg_rd_data;
    logic              cfg_rd_data_valid;

    modport master (
        output cfg_wr_clk_en, cfg_wr_en, cfg_wr_addr, cfg_wr_data,
               cfg_rd_clk_en, cfg_rd_en, cfg_rd_addr,
        input  cfg_rd_data, cfg_rd_data_valid
    );

    modport slave (
        input  cfg_wr_clk_en, cfg_wr_en, cfg_wr_addr, cfg_wr_data,
               cfg_rd_clk_en, cfg_rd_en, cfg_rd_addr,
        output cfg_rd_data, cfg_rd_data_valid
    );
endinterface

// File: rtl/glb_cfg_initiator.sv
// Master end of the tile configuration bus. Takes one host PIO request at a
// time, sequences cfg clock-enable / strobe / address / data toward the tile
// chain, waits (with timeout) for read data, and returns one response.
// Ports:
//   clk, reset : single clock, asynchronous active-high reset
//   host       : glb_host_if.slave  - request in, response out
//   cfg        : glb_cfg_if.master  - cfg write/read bus to the tiles
// All outputs are registered.

module glb_cfg_initiator #(
    parameter int unsigned CFG_ADDR_WIDTH = 12,
    parameter int unsigned CFG_DATA_WIDTH = 32,
    parameter int unsigned RD_TIMEOUT     = 63
) (
    input  logic       clk,
    input  logic       reset,
    glb_host_if.slave  host,
    glb_cfg_if.master  cfg
);

    localparam int unsigned TO_WIDTH = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ISSUE,
        RD_SETUP,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    state_t                    state;
    logic [TO_WIDTH-1:0]       to_cnt;
    logic [CFG_ADDR_WIDTH-1:0] addr_q;
    logic [CFG_DATA_WIDTH-1:0] data_q;

    // Sequencer: every output is updated here alongside the state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            to_cnt             <= '0;
            addr_q             <= '0;
            data_q             <= '0;
            host.req_ready     <= 1'b1;
            host.resp_valid    <= 1'b0;
            host.resp_data     <= '0;
            host.resp_err      <= 1'b0;
            cfg.cfg_wr_clk_en  <= 1'b0;
            cfg.cfg_wr_en      <= 1'b0;
            cfg.cfg_wr_addr    <= '0;
            cfg.cfg_wr_data    <= '0;
            cfg.cfg_rd_clk_en  <= 1'b0;
            cfg.cfg_rd_en      <= 1'b0;
            cfg.cfg_rd_addr    <= '0;
        end else begin
            case (state)
                // req_ready is high exactly while in IDLE, so valid alone is the handshake.
                IDLE: begin
                    if (host.req_valid) begin
                        addr_q         <= host.req_addr;
                        data_q         <= host.req_data;
                        host.req_ready <= 1'b0;
                        if (host.req_write) begin
                            state             <= WR_SETUP;
                            cfg.cfg_wr_clk_en <= 1'b1;
                        end else begin
                            state             <= RD_SETUP;
                            cfg.cfg_rd_clk_en <= 1'b1;
                        end
                    end
                end

                WR_SETUP: begin
                    state           <= WR_ISSUE;
                    cfg.cfg_wr_en   <= 1'b1;
                    cfg.cfg_wr_addr <= addr_q;
                    cfg.cfg_wr_data <= data_q;
                end

                WR_ISSUE: begin
                    state             <= RESP;
                    cfg.cfg_wr_clk_en <= 1'b0;
                    cfg.cfg_wr_en     <= 1'b0;
                    cfg.cfg_wr_addr   <= '0;
                    cfg.cfg_wr_data   <= '0;
                    host.resp_valid   <= 1'b1;
                    host.resp_data    <= '0;
                    host.resp_err     <= 1'b0;
                end

                RD_SETUP: begin
                    state           <= RD_ISSUE;
                    cfg.cfg_rd_en   <= 1'b1;
                    cfg.cfg_rd_addr <= addr_q;
                end

                RD_ISSUE: begin
                    state           <= RD_WAIT;
                    cfg.cfg_rd_en   <= 1'b0;
                    cfg.cfg_rd_addr <= '0;
                    to_cnt          <= '0;
                end

                // Returned data takes priority over a timeout landing in the same cycle.
                RD_WAIT: begin
                    if (cfg.cfg_rd_data_valid) begin
                        state             <= RESP;
                        cfg.cfg_rd_clk_en <= 1'b0;
                        host.resp_valid   <= 1'b1;
                        host.resp_data    <= cfg.cfg_rd_data;
                        host.resp_err     <= 1'b0;
                    end else if (to_cnt == TO_WIDTH'(RD_TIMEOUT - 1)) begin
                        state             <= RESP;
                        cfg.cfg_rd_clk_en <= 1'b0;
                        host.resp_valid   <= 1'b1;
                        host.resp_data    <= '0;
                        host.resp_err     <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_WIDTH'(1);
                    end
                end

                // Response held stable until consumed; no new request in the consume cycle.
                RESP: begin
                    if (host.resp_ready) begin
                        state           <= IDLE;
                        host.resp_valid <= 1'b0;
                        host.resp_data  <= '0;
                        host.resp_err   <= 1'b0;
                        host.req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    host.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glb_cfg_initiator.sv
// Directed bench for glb_cfg_initiator: writes, reads with returned data,
// read timeout, response backpressure, stray read-valid pulses and
// asynchronous reset in the middle of transactions.

module tb_glb_cfg_initiator;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 63;

    logic clk = 1'b0;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int overlap = 0;
    int waits;
    int p0;

    glb_host_if #(.ADDR_W(AW), .DATA_W(DW)) h_if ();
    glb_cfg_if  #(.ADDR_W(AW), .DATA_W(DW)) c_if ();

    glb_cfg_initiator #(
        .CFG_ADDR_WIDTH (AW),
        .CFG_DATA_WIDTH (DW),
        .RD_TIMEOUT     (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (h_if),
        .cfg   (c_if)
    );

    always #5 clk = ~clk;

    // Strobe bookkeeping sampled away from the active edge.
    always @(negedge clk) begin
        if (c_if.cfg_wr_en) wr_pulses++;
        if (c_if.cfg_wr_en && c_if.cfg_rd_en) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a request from IDLE; returns at the negedge after the handshake edge.
    task automatic host_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk("req_ready_idle", h_if.req_ready, 1);
        h_if.req_valid = 1'b1;
        h_if.req_write = w;
        h_if.req_addr  = a;
        h_if.req_data  = d;
        @(negedge clk);
        h_if.req_valid = 1'b0;
        chk("req_ready_busy", h_if.req_ready, 0);
    endtask

    task automatic consume();
        h_if.resp_ready = 1'b1;
        @(negedge clk);
        h_if.resp_ready = 1'b0;
        chk("consume_resp_valid", h_if.resp_valid, 0);
        chk("consume_req_ready", h_if.req_ready, 1);
    endtask

    // Full write up to the RESP cycle.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req(1'b1, a, d);
        chk("wr_setup_clk_en", c_if.cfg_wr_clk_en, 1);
        chk("wr_setup_en", c_if.cfg_wr_en, 0);
        chk("wr_setup_addr", c_if.cfg_wr_addr, 0);
        @(negedge clk);
        chk("wr_issue_clk_en", c_if.cfg_wr_clk_en, 1);
        chk("wr_issue_en", c_if.cfg_wr_en, 1);
        chk("wr_issue_addr", c_if.cfg_wr_addr, a);
        chk("wr_issue_data", c_if.cfg_wr_data, d);
        chk("wr_issue_rd_clk_en", c_if.cfg_rd_clk_en, 0);
        @(negedge clk);
        chk("wr_resp_valid", h_if.resp_valid, 1);
        chk("wr_resp_err", h_if.resp_err, 0);
        chk("wr_resp_data", h_if.resp_data, 0);
        chk("wr_resp_clk_en", c_if.cfg_wr_clk_en, 0);
        chk("wr_resp_en", c_if.cfg_wr_en, 0);
        chk("wr_resp_wdata", c_if.cfg_wr_data, 0);
    endtask

    // Full read up to the RESP cycle; valid is driven on RD_WAIT cycle vld_at (0 = never).
    task automatic do_read(input logic [AW-1:0] a, input int vld_at, input logic [DW-1:0] d,
                           output int nw);
        bit got;
        got = 1'b0;
        nw  = 0;
        host_req(1'b0, a, '0);
        chk("rd_setup_clk_en", c_if.cfg_rd_clk_en, 1);
        chk("rd_setup_en", c_if.cfg_rd_en, 0);
        chk("rd_setup_wr_clk_en", c_if.cfg_wr_clk_en, 0);
        @(negedge clk);
        chk("rd_issue_clk_en", c_if.cfg_rd_clk_en, 1);
        chk("rd_issue_en", c_if.cfg_rd_en, 1);
        chk("rd_issue_addr", c_if.cfg_rd_addr, a);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            c_if.cfg_rd_data_valid = 1'b0;
            c_if.cfg_rd_data       = 32'hBAD0_BAD0;
            if (h_if.resp_valid) begin
                got = 1'b1;
                break;
            end
            nw++;
            if (nw == 1) begin
                chk("rd_wait_en", c_if.cfg_rd_en, 0);
                chk("rd_wait_addr", c_if.cfg_rd_addr, 0);
                chk("rd_wait_clk_en", c_if.cfg_rd_clk_en, 1);
            end
            if (nw == vld_at) begin
                c_if.cfg_rd_data_valid = 1'b1;
                c_if.cfg_rd_data       = d;
            end
        end
        chk("rd_resp_seen", got, 1);
        chk("rd_resp_clk_en", c_if.cfg_rd_clk_en, 0);
    endtask

    initial begin
        reset                  = 1'b1;
        h_if.req_valid         = 1'b0;
        h_if.req_write         = 1'b0;
        h_if.req_addr          = '0;
        h_if.req_data          = '0;
        h_if.resp_ready        = 1'b0;
        c_if.cfg_rd_data       = '0;
        c_if.cfg_rd_data_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", h_if.req_ready, 1);
        chk("rst_resp_valid", h_if.resp_valid, 0);
        chk("rst_wr_clk_en", c_if.cfg_wr_clk_en, 0);
        chk("rst_rd_clk_en", c_if.cfg_rd_clk_en, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic write
        do_write(12'h01C, 32'hDEAD_BEEF);
        consume();

        // 2: read, data returned on third RD_WAIT cycle
        do_read(12'h040, 3, 32'h1234_5678, waits);
        chk("t2_waits", waits, 3);
        chk("t2_resp_data", h_if.resp_data, 32'h1234_5678);
        chk("t2_resp_err", h_if.resp_err, 0);
        consume();

        // 3: timeout, then valid on the final RD_WAIT cycle
        do_read(12'h3FF, 0, '0, waits);
        chk("t3_to_waits", waits, TO);
        chk("t3_to_err", h_if.resp_err, 1);
        chk("t3_to_data", h_if.resp_data, 0);
        consume();
        do_read(12'h2A0, TO, 32'h600D_D00D, waits);
        chk("t3_edge_waits", waits, TO);
        chk("t3_edge_err", h_if.resp_err, 0);
        chk("t3_edge_data", h_if.resp_data, 32'h600D_D00D);
        consume();

        // 4: response backpressure with a new request held pending
        do_read(12'h123, 1, 32'hCAFE_F00D, waits);
        h_if.req_valid = 1'b1;
        h_if.req_write = 1'b1;
        h_if.req_addr  = 12'h0AA;
        h_if.req_data  = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", h_if.resp_valid, 1);
            chk("t4_hold_data", h_if.resp_data, 32'hCAFE_F00D);
            chk("t4_hold_req_ready", h_if.req_ready, 0);
        end
        h_if.resp_ready = 1'b1;
        @(negedge clk);
        h_if.resp_ready = 1'b0;
        chk("t4_after_resp_valid", h_if.resp_valid, 0);
        chk("t4_after_req_ready", h_if.req_ready, 1);
        chk("t4_not_yet_taken", c_if.cfg_wr_clk_en, 0);
        @(negedge clk);
        h_if.req_valid = 1'b0;
        chk("t4_taken_clk_en", c_if.cfg_wr_clk_en, 1);
        chk("t4_taken_req_ready", h_if.req_ready, 0);
        @(negedge clk);
        chk("t4_wr_en", c_if.cfg_wr_en, 1);
        chk("t4_wr_addr", c_if.cfg_wr_addr, 12'h0AA);
        chk("t4_wr_data", c_if.cfg_wr_data, 32'h1111_1111);
        @(negedge clk);
        chk("t4_resp_valid", h_if.resp_valid, 1);
        consume();

        // 5: stray read-valid in IDLE, through a write, and through RD_SETUP/RD_ISSUE
        c_if.cfg_rd_data_valid = 1'b1;
        c_if.cfg_rd_data       = 32'h9999_9999;
        repeat (2) @(negedge clk);
        chk("t5_idle_req_ready", h_if.req_ready, 1);
        chk("t5_idle_resp_valid", h_if.resp_valid, 0);
        chk("t5_idle_rd_clk_en", c_if.cfg_rd_clk_en, 0);
        do_write(12'h0C3, 32'h0F0F_0F0F);
        consume();
        do_read(12'h0D4, 2, 32'h5555_AAAA, waits);
        chk("t5_rd_waits", waits, 2);
        chk("t5_rd_data", h_if.resp_data, 32'h5555_AAAA);
        chk("t5_rd_err", h_if.resp_err, 0);
        consume();

        // 6: async reset in WR_SETUP, then in RD_WAIT
        p0 = wr_pulses;
        host_req(1'b1, 12'h077, 32'h7777_7777);
        #2 reset = 1'b1;
        #1;
        chk("t6a_req_ready", h_if.req_ready, 1);
        chk("t6a_wr_clk_en", c_if.cfg_wr_clk_en, 0);
        chk("t6a_wr_en", c_if.cfg_wr_en, 0);
        chk("t6a_resp_valid", h_if.resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6a_no_wr_pulse", wr_pulses, p0);
        chk("t6a_idle_resp_valid", h_if.resp_valid, 0);

        host_req(1'b0, 12'h155, '0);
        repeat (3) @(negedge clk);
        chk("t6b_in_wait", c_if.cfg_rd_clk_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6b_req_ready", h_if.req_ready, 1);
        chk("t6b_rd_clk_en", c_if.cfg_rd_clk_en, 0);
        chk("t6b_rd_en", c_if.cfg_rd_en, 0);
        chk("t6b_resp_valid", h_if.resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6b_idle_resp_valid", h_if.resp_valid, 0);
        do_write(12'h0F0, 32'h0BAD_CAFE);
        consume();

        chk("wr_pulse_total", wr_pulses, 4);
        chk("strobe_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/glb_cfg_initiator.md
Name: glb_cfg_initiator

Overview:
- Master end of the tile configuration bus; drives cfg write/read transactions into the westmost tile's cfg slave port, which the tile chain forwards eastward.
- Accepts one host PIO request at a time over a valid/ready channel and sequences the cfg clock-enable, enable, address and data signals.
- For reads, waits for read data to return, with a timeout.
- Returns one response per request over a valid/ready response channel.

Parameters:
- CFG_ADDR_WIDTH, 12, cfg address width.
- CFG_DATA_WIDTH, 32, cfg data width.
- RD_TIMEOUT, 63, maximum cycles spent in RD_WAIT before a read is failed; legal range 1..1023.
- TO_WIDTH, $clog2(RD_TIMEOUT+1), derived timeout counter width; not overridden.

Ports:
- clk  input  1  clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  CFG_ADDR_WIDTH  target address.
- req_data  input  CFG_DATA_WIDTH  write data; ignored for reads.
- resp_valid  output  1  response valid.
- resp_ready  input  1  host consumes response.
- resp_data  output  CFG_DATA_WIDTH  read data; 0 for writes and errors.
- resp_err  output  1  1 = read timeout.
- cfg_wr_clk_en  output  1  write clock enable to the tile chain.
- cfg_wr_en  output  1  write strobe.
- cfg_wr_addr  output  CFG_ADDR_WIDTH  write address.
- cfg_wr_data  output  CFG_DATA_WIDTH  write data.
- cfg_rd_clk_en  output  1  read clock enable.
- cfg_rd_en  output  1  read strobe.
- cfg_rd_addr  output  CFG_ADDR_WIDTH  read address.
- cfg_rd_data  input  CFG_DATA_WIDTH  returned read data.
- cfg_rd_data_valid  input  1  returned data valid.

Behaviour:
- All outputs are registered.
- Reset (async assert, any state): state IDLE; timeout counter 0; all outputs 0 except req_ready, which is 1.
- The reset values of req_ready=1 and all other outputs=0 also apply after a reset mid-transaction. A pending response is dropped and no bus strobe completes.
- FSM states: IDLE, WR_SETUP, WR_ISSUE, RD_SETUP, RD_ISSUE, RD_WAIT, RESP.
- req_ready is 1 only in IDLE. The request is latched on handshake at edge t.
- Write path:
  - t+1 WR_SETUP: wr_clk_en=1, wr_en=0.
  - t+2 WR_ISSUE: wr_clk_en=1, wr_en=1, wr_addr/wr_data = latched values for exactly one cycle.
  - t+3 RESP with resp_err=0, resp_data=0.
- Read path:
  - t+1 RD_SETUP: rd_clk_en=1.
  - t+2 RD_ISSUE: rd_clk_en=1, rd_en=1, rd_addr = latched address for exactly one cycle.
  - t+3 onward RD_WAIT: rd_clk_en=1, rd_en=0, rd_addr=0.
- RD_WAIT exit:
  - cfg_rd_data_valid=1 in RD_WAIT: capture cfg_rd_data into resp_data; next state RESP with resp_err=0.
  - Otherwise the counter increments each RD_WAIT cycle. When the counter == RD_TIMEOUT-1 and valid is 0, next state is RESP with resp_err=1, resp_data=0.
  - If valid arrives in the same cycle as timeout, valid wins (err=0).
  - The counter clears on RD_WAIT entry.
- cfg_rd_data_valid outside RD_WAIT (stray or late) is ignored and has no effect on state or outputs.
- wr_addr, wr_data and rd_addr are 0 whenever their strobe is 0. Clock enables are 0 in IDLE and RESP.
- RESP: resp_valid=1; resp_data and resp_err are stable until resp_ready. On resp_ready=1, next state is IDLE with resp_valid=0, req_ready=1.
- resp_valid and req_ready are never high together, so no new request is taken in the cycle the response is consumed. Minimum request-to-request spacing is therefore 4 cycles for a write and 5 for a read.
- Read and write strobes are never active in the same cycle.

Test Plan:
1. Write addr=0x01C, data=0xDEADBEEF: wr_clk_en high 2 cycles, wr_en high exactly 1 cycle with addr 0x01C / data 0xDEADBEEF, then resp_valid at t+3 with err=0, data=0.
2. Read addr=0x040, cfg_rd_data_valid with data 0x12345678 three cycles into RD_WAIT: rd_en high 1 cycle with addr 0x040; response data=0x12345678, err=0; rd_clk_en drops on RESP entry.
3. Read with no return (RD_TIMEOUT=63): exactly 63 RD_WAIT cycles, then resp_err=1, data=0. Repeat with valid on the 63rd cycle: err=0 and data captured.
4. Response backpressure: resp_ready low for 10 cycles with req_valid held high. resp_data/err stay stable and req_ready stays 0; a second request is accepted only in the cycle after resp_ready.
5. Stray cfg_rd_data_valid pulses during IDLE, a write, and RD_SETUP/RD_ISSUE: no state change; a subsequent read returns only data arriving in RD_WAIT.
6. Assert reset asynchronously during WR_SETUP and during RD_WAIT: all outputs 0 and req_ready=1 immediately. No wr_en pulse occurs; a following write completes normally.
